// File: rtl/barrel_normalizer_8bit.sv
// ============================================================================
//  Module      : barrel_normalizer_8bit
//  Description : Serial left-normaliser that recovers an MSB-aligned word and
//                its leading-zero count, with valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_normalizer_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(WIDTH)-1:0] ctrl,
    output logic                     zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic             r_zero;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_aligned;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    // A zero word passes through SHIFT for one edge so it shares the k=0 latency.
    assign w_aligned = r_data[WIDTH-1] || r_zero;

    assign out       = r_data;
    assign ctrl      = r_count;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)              w_next = SHIFT;
            SHIFT:   if (w_aligned)             w_next = DONE;
            DONE:    if (out_ready)             w_next = IDLE;
            default:                            w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_count     <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= in;
                        r_count <= '0;
                        r_zero  <= (in == '0);
                    end
                end
                SHIFT: begin
                    if (w_aligned) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_data  <= {r_data[WIDTH-2:0], 1'b0};
                        r_count <= r_count + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_barrel_normalizer_8bit.sv
// ============================================================================
//  Module      : tb_barrel_normalizer_8bit
//  Description : Directed self-checking bench for barrel_normalizer_8bit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_barrel_normalizer_8bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [2:0] ctrl;
    logic       zero;

    int compared;
    int mismatched;

    barrel_normalizer_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ctrl      (ctrl),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, then measure edges from accept to out_valid.
    task automatic run_word(input string tag, input logic [7:0] word,
                            input logic [7:0] exp_out, input logic [2:0] exp_ctrl,
                            input logic exp_zero, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in       = word;
        tick();
        in_valid = 1'b0;
        in       = 8'hxx;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_out"},     {24'd0, out},      {24'd0, exp_out});
        check({tag, "_ctrl"},    {29'd0, ctrl},     {29'd0, exp_ctrl});
        check({tag, "_zero"},    {31'd0, zero},     {31'd0, exp_zero});
        if (out_ready) begin
            tick();
            check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] d;
        int         s;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in         = 8'd0;
        out_ready  = 1'b1;

        tick();
        tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out",       {24'd0, out},       32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a shift sequence
        in_valid = 1'b1;
        in       = 8'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out",       {24'd0, out},       32'd0);
        check("async_ctrl",      {29'd0, ctrl},      32'd0);
        check("async_zero",      {31'd0, zero},      32'd0);
        check("async_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_word("aligned",  8'd128, 8'd128, 3'd0, 1'b0, 1);
        run_word("shift4",   8'd8,   8'd128, 3'd4, 1'b0, 5);
        run_word("shift2",   8'd32,  8'd128, 3'd2, 1'b0, 3);
        run_word("shift7",   8'd1,   8'd128, 3'd7, 1'b0, 8);
        run_word("zero_in",  8'd0,   8'd0,   3'd0, 1'b1, 1);
        run_word("mixed",    8'b0000_0101, 8'b1010_0000, 3'd5, 1'b0, 6);

        // Backpressure: hold result in DONE while input activity is ignored
        out_ready = 1'b0;
        run_word("bp", 8'b0001_0110, 8'b1011_0000, 3'd3, 1'b0, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in       = 8'h40 + 8'(i);
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_out",   {24'd0, out},       {24'd0, 8'b1011_0000});
            check("bp_hold_ctrl",  {29'd0, ctrl},      32'd3);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_handshake", {31'd0, out_valid}, 32'd0);
        check("bp_ready",     {31'd0, in_ready},  32'd1);
        tick();
        check("bp_no_second", {31'd0, out_valid}, 32'd0);

        // Round trip against a logical right shift
        for (int w = 0; w < 500; w++) begin
            s = int'($urandom_range(7, 0));
            d = (8'h80 | 8'($urandom)) & (8'hFF << s);
            run_word("round_trip", d >> s, d, 3'(s), 1'b0, s + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
